// File: rtl/chacha_pkg.sv
// Shared ChaCha types, constants, index tables and helpers.
package chacha_pkg;

    localparam int unsigned WordW    = 32;
    localparam int unsigned NumWords = 16;
    localparam int unsigned StateW   = WordW * NumWords;

    typedef logic [WordW-1:0]          word_t;
    typedef word_t [NumWords-1:0]      state_t;
    typedef logic [3:0]                idx_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // "expand 32-byte k"
    localparam word_t Sigma0 = 32'h61707865;
    localparam word_t Sigma1 = 32'h3320646e;
    localparam word_t Sigma2 = 32'h79622d32;
    localparam word_t Sigma3 = 32'h6b206574;

    // Row q lists the (a, b, c, d) word indices of quarter round q.
    localparam idx_t ColIdx [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam idx_t DiagIdx [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WordW - n));
    endfunction

    function automatic state_t unpack_state(input logic [StateW-1:0] v);
        state_t s;
        for (int i = 0; i < NumWords; i++) begin
            s[i] = v[WordW*i +: WordW];
        end
        return s;
    endfunction

    function automatic logic [StateW-1:0] pack_state(input state_t s);
        logic [StateW-1:0] v;
        for (int i = 0; i < NumWords; i++) begin
            v[WordW*i +: WordW] = s[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [WordW-1:0] a_i,
    input  logic [WordW-1:0] b_i,
    input  logic [WordW-1:0] c_i,
    input  logic [WordW-1:0] d_i,
    output logic [WordW-1:0] a_o,
    output logic [WordW-1:0] b_o,
    output logic [WordW-1:0] c_o,
    output logic [WordW-1:0] d_o
);

    word_t a1, b1, c1, d1;
    word_t a2, b2, c2, d2;

    // Two add-xor-rotate half steps, written out in ARX order.
    always_comb begin
        a1 = a_i + b_i;
        d1 = rotl(d_i ^ a1, 16);
        c1 = c_i + d1;
        b1 = rotl(b_i ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl(b1 ^ c2, 7);
    end

    assign a_o = a2;
    assign b_o = b2;
    assign c_o = c2;
    assign d_o = d2;

endmodule

// File: rtl/chacha_core.sv
// Iterative ChaCha permutation: one round per clock, valid/ready on both sides.
module chacha_core
    import chacha_pkg::*;
#(
    parameter int unsigned ROUNDS   = 20,
    parameter bit          FEED_FWD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [StateW-1:0] in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [StateW-1:0] out_state,
    output logic              busy
);

    localparam int unsigned    CntW      = $clog2(ROUNDS) + 1;
    localparam logic [CntW-1:0] LastRound = CntW'(ROUNDS - 1);

    state_e          state_q, state_d;
    state_t          work_q, work_d;
    state_t          orig_q, orig_d;
    state_t          out_q, out_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;

    state_t round_res;
    state_t ff_res;
    idx_t   sel [4][4];
    word_t  qa_i [4], qb_i [4], qc_i [4], qd_i [4];
    word_t  qa_o [4], qb_o [4], qc_o [4], qd_o [4];
    logic   last_round;

    assign last_round = (cnt_q == LastRound);

    // Operand routing: even count uses columns, odd count uses diagonals.
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            for (int k = 0; k < 4; k++) begin
                sel[q][k] = cnt_q[0] ? DiagIdx[q][k] : ColIdx[q][k];
            end
            qa_i[q] = work_q[sel[q][0]];
            qb_i[q] = work_q[sel[q][1]];
            qc_i[q] = work_q[sel[q][2]];
            qd_i[q] = work_q[sel[q][3]];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_qr u_qr (
            .a_i (qa_i[g]),
            .b_i (qb_i[g]),
            .c_i (qc_i[g]),
            .d_i (qd_i[g]),
            .a_o (qa_o[g]),
            .b_o (qb_o[g]),
            .c_o (qc_o[g]),
            .d_o (qd_o[g])
        );
    end

    // Scatter quarter-round results back; the four QRs touch disjoint words.
    always_comb begin
        round_res = work_q;
        for (int q = 0; q < 4; q++) begin
            round_res[sel[q][0]] = qa_o[q];
            round_res[sel[q][1]] = qb_o[q];
            round_res[sel[q][2]] = qc_o[q];
            round_res[sel[q][3]] = qd_o[q];
        end
    end

    // Feed-forward adders applied to the state produced by the final round.
    always_comb begin
        for (int i = 0; i < NumWords; i++) begin
            ff_res[i] = FEED_FWD ? (round_res[i] + orig_q[i]) : round_res[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (last_round) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: in_ready and busy depend on state only.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = out_valid_q;
        out_state = pack_state(out_q);
    end

    // Datapath next-state: latch on accept, one round per RUN edge, hold in DONE.
    always_comb begin
        work_d      = work_q;
        orig_d      = orig_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d = unpack_state(in_state);
                    orig_d = unpack_state(in_state);
                    cnt_d  = '0;
                end
            end
            StRun: begin
                work_d = round_res;
                cnt_d  = cnt_q + CntW'(1);
                if (last_round) begin
                    out_d       = ff_res;
                    out_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q      <= '0;
            orig_q      <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            work_q      <= work_d;
            orig_q      <= orig_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_chacha_core.sv
// Self-checking bench for chacha_core with a scoreboard on the ROUNDS=20 instance.
module tb_chacha_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ChaCha model
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] ref_block(input logic [511:0] s, input int rounds,
                                               input bit ff);
        logic [31:0] x [16];
        logic [511:0] r;
        int ix [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int n = 0; n < rounds; n++) begin
            for (int q = 0; q < 4; q++) begin
                int a, b, c, d, row;
                row = (n % 2) * 4 + q;
                a = ix[row][0]; b = ix[row][1]; c = ix[row][2]; d = ix[row][3];
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + (ff ? s[32*i +: 32] : 32'd0);
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Main DUT: ROUNDS=20, FEED_FWD=1
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [511:0] out_state;
    logic         busy;

    chacha_core #(.ROUNDS(20), .FEED_FWD(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    // Small DUTs: index 0 is ROUNDS=8 raw permutation, index 1 is ROUNDS=12 block function
    logic         sm_in_valid  [2];
    logic         sm_in_ready  [2];
    logic [511:0] sm_in_state  [2];
    logic         sm_out_valid [2];
    logic         sm_out_ready [2];
    logic [511:0] sm_out_state [2];
    logic         sm_busy      [2];

    for (genvar g = 0; g < 2; g++) begin : g_sm
        chacha_core #(.ROUNDS(g == 0 ? 8 : 12), .FEED_FWD(g == 0 ? 1'b0 : 1'b1)) u_sm (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sm_in_valid[g]),
            .in_ready  (sm_in_ready[g]),
            .in_state  (sm_in_state[g]),
            .out_valid (sm_out_valid[g]),
            .out_ready (sm_out_ready[g]),
            .out_state (sm_out_state[g]),
            .busy      (sm_busy[g])
        );
    end

    // Standalone quarter round
    logic [31:0] qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;
    chacha_qr u_qr (
        .a_i (qa), .b_i (qb), .c_i (qc), .d_i (qd),
        .a_o (qa_o), .b_o (qb_o), .c_o (qc_o), .d_o (qd_o)
    );

    // Scoreboard for the main DUT
    logic [511:0] exp_q [$];
    int           acc_q [$];
    int           last_acc;
    logic         prev_valid = 1'b0;
    logic         prev_hs = 1'b0;

    always @(negedge clk) begin
        if (prev_hs) check_eq("ov_one_cycle", out_valid, 1'b0);
        if (out_valid && !prev_valid) begin
            if (acc_q.size() == 0) check_eq("latency_no_accept", 1'b1, 1'b0);
            else check_eq("latency20", cyc - acc_q.pop_front(), 20);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_out", 1'b1, 1'b0);
            else check_eq("out_state", out_state, exp_q.pop_front());
        end
        prev_hs    <= out_valid && out_ready;
        prev_valid <= out_valid;
    end

    task automatic send(input logic [511:0] s, input bit hold);
        int n;
        @(negedge clk);
        in_state = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        acc_q.push_back(cyc);
        exp_q.push_back(ref_block(s, 20, 1'b1));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_small(input int k, input int rounds, input bit ff,
                             input logic [511:0] s);
        int t0, n;
        @(negedge clk);
        sm_in_state[k]  = s;
        sm_in_valid[k]  = 1'b1;
        sm_out_ready[k] = 1'b1;
        check_eq("sm_in_ready", sm_in_ready[k], 1'b1);
        @(posedge clk);
        #1;
        sm_in_valid[k] = 1'b0;
        t0 = cyc;
        n = 0;
        @(negedge clk);
        while (!sm_out_valid[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sm_latency", cyc - t0, rounds);
        check_eq("sm_out_state", sm_out_state[k], ref_block(s, rounds, ff));
        @(negedge clk);
        check_eq("sm_valid_drop", sm_out_valid[k], 1'b0);
    endtask

    logic [511:0] rfc, va, vb;
    int           t1;

    initial begin
        for (int k = 0; k < 2; k++) begin
            sm_in_valid[k]  = 1'b0;
            sm_in_state[k]  = '0;
            sm_out_ready[k] = 1'b1;
        end
        rfc = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
               32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
               32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
               32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

        // Quarter round unit vector
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1;
        check_eq("qr_a", qa_o, 32'hea2a92f4);
        check_eq("qr_b", qb_o, 32'hcb1cf8ce);
        check_eq("qr_c", qc_o, 32'h4581472e);
        check_eq("qr_d", qd_o, 32'h5881c4bb);

        // Reset state
        #2;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_out_state", out_state, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Other round counts: zero state and a random state
        run_small(0, 8, 1'b0, '0);
        run_small(1, 12, 1'b1, '0);
        run_small(0, 8, 1'b0, rand_state());
        run_small(1, 12, 1'b1, rand_state());

        // RFC 8439 block
        send(rfc, 1'b0);
        wait_valid();
        check_eq("rfc_w0", out_state[31:0], 32'he4e7f110);
        check_eq("rfc_w1", out_state[63:32], 32'h15593bd1);
        check_eq("rfc_w15", out_state[511:480], 32'h4e3c50a2);
        check_eq("busy_run", busy, 1'b1);

        // All-zero block at 20 rounds
        send('0, 1'b0);
        wait_valid();
        check_eq("zero20", out_state, '0);

        // Backpressure with an ignored in_valid pulse
        @(negedge clk);
        out_ready = 1'b0;
        va = rand_state();
        vb = rand_state();
        send(va, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_hold", out_state, ref_block(va, 20, 1'b1));
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_valid", out_valid, 1'b1);
            if (i == 3) begin
                in_state = vb;
                in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("bp_idle_busy", busy, 1'b0);
        check_eq("bp_idle_valid", out_valid, 1'b0);

        // Reset in the middle of a block
        send(rand_state(), 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_out_state", out_state, '0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) check_eq("stale_valid", out_valid, 1'b0);
        end
        send(rand_state(), 1'b0);
        wait_valid();

        // Back-to-back with in_valid and out_ready high
        @(negedge clk);
        send(rfc, 1'b1);
        t1 = last_acc;
        va = rand_state();
        send(va, 1'b0);
        check_eq("b2b_gap", last_acc - t1, 22);

        // Drain the scoreboard
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
